sram_1rw1r_model: RTL and testbench
===================================

Name: sram_1rw1r_model

Overview:
- Parametrised behavioural SRAM model: one read/write port (port 0) and one read-only port (port 1).
- Per-segment write mask, configurable read latency and depth, and read-valid strobes.
- Successor to the single-port tri-state SRAM model; uses separate din/dout buses instead of a bidirectional data bus.
- Used as the macro stand-in for RTL simulation of generated SRAMs and for datasheet timing checks.

Parameters:
- WORD_SIZE, 32, data bits per word.
- WRITE_SIZE, 8, bits per write-mask segment; WORD_SIZE must be a multiple of WRITE_SIZE.
- NUM_WMASK, WORD_SIZE/WRITE_SIZE, number of write-mask bits (derived).
- ADDR_WIDTH, 8, address bits.
- NUM_WORDS, 1<<ADDR_WIDTH, implemented depth; must be ≤ 2^ADDR_WIDTH.
- READ_LATENCY, 1, clocks from read-accept edge to data valid; legal range 1..4.

Ports:
- clk  in  1  clock; all activity on rising edge.
- rst_n  in  1  synchronous reset, active low.
- csb0  in  1  port 0 chip select, active low.
- web0  in  1  port 0 write enable, active low.
- wmask0  in  NUM_WMASK  port 0 segment write mask, 1 = write segment.
- addr0  in  ADDR_WIDTH  port 0 address.
- din0  in  WORD_SIZE  port 0 write data.
- dout0  out  WORD_SIZE  port 0 read data.
- dout0_valid  out  1  port 0 read data valid, one pulse per read.
- csb1  in  1  port 1 chip select, active low.
- addr1  in  ADDR_WIDTH  port 1 address.
- dout1  out  WORD_SIZE  port 1 read data.
- dout1_valid  out  1  port 1 read data valid.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-low.
- Reset (rst_n=0 at edge):
  - dout0, dout1 = 0; dout0_valid, dout1_valid = 0.
  - All read-pipeline stages cleared, so in-flight reads are dropped.
  - Memory array contents untouched.
  - Accesses presented in a reset cycle are ignored, writes included.
- Write:
  - Accepted at edge when rst_n=1, csb0=0, web0=0.
  - Segment i (bits i*WRITE_SIZE +: WRITE_SIZE) is updated only if wmask0[i]=1.
  - wmask0=0 is a legal no-op write.
- Read port 0:
  - Accepted when csb0=0, web0=1.
  - Read port 1: accepted when csb1=0.
- Read pipeline:
  - Each port has a READ_LATENCY-deep pipeline of {valid, data}.
  - Array sampled at the accept edge; data and valid appear READ_LATENCY edges later.
  - Back-to-back reads every cycle are supported; one result per cycle.
- Output hold:
  - dout holds its last valid value until the next valid result.
  - dout_valid is high exactly one cycle per accepted read.
- Port 0 write cycles produce no dout0_valid; dout0 holds.
- Out-of-range address (≥ NUM_WORDS):
  - Write ignored.
  - Read returns all-zero with valid asserted normally.
- Same address, port 1 read and port 0 write in the same edge: result is set by the optional feature below.
- Both ports reading the same address: identical data.
- X/Z on csb or web while rst_n=1: treated as no access.

Optional Feature:
- Macro: SRAM_WRITE_THROUGH_EN.
- Defined (write-through): a port 1 read colliding with a port 0 write to the same address returns the merged new word (masked segments from din0, the rest from the old content).
- Undefined (read-before-write): the colliding port 1 read returns the pre-write word.
- Non-colliding behaviour is identical in both builds.

Decomposition:
- Package sram_model_pkg holds:
  - the latency range constants (MIN_READ_LATENCY=1, MAX_READ_LATENCY=4);
  - a typedef for the pipeline stage struct {valid, data};
  - a function merge_wmask(old, new, mask) used by the write and forward paths.
- One sub-module, sram_read_pipe:
  - parametrised by WORD_SIZE and READ_LATENCY;
  - takes an accept strobe and a data word, and produces dout/dout_valid with the hold and reset rules above;
  - instantiated once per port.

Test Plan:
- Reset then idle, READ_LATENCY=2: dout0=dout1=0 and both valids=0 for 10 cycles.
- Full write: write addr0=0x05, din0=0xDEADBEEF, wmask0=4'b1111; then read port 1 addr1=0x05 → dout1=0xDEADBEEF with dout1_valid high exactly 2 edges after accept.
- Partial write: then write 0x05 with din0=0x11223344, wmask0=4'b0101 → port 0 read returns 0xDE22BE44.
- Collision:
  - Port 0 writes 0x07 (old 0xAAAAAAAA) with din0=0x55555555, full mask, while port 1 reads 0x07 on the same edge.
  - dout1=0xAAAAAAAA without SRAM_WRITE_THROUGH_EN; 0x55555555 with it.
- Reset mid-read: accept a read at edge N, assert rst_n=0 at edge N+1 → no dout_valid pulse follows, dout=0; a write in the reset cycle leaves memory unchanged.
- Streaming and range: 16 back-to-back port 1 reads of addresses 0..15 → 16 consecutive valid cycles in order. With NUM_WORDS=200, a read of 0xF0 returns 0, and a write to 0xF0 is ignored.

Source files
------------

// File: rtl/sram_model_pkg.sv
// ============================================================================
// Module  : sram_model_pkg
// Purpose : Shared types, latency limits and the write-mask merge helper used
//           by the 1RW1R SRAM behavioural model and its read pipelines.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package sram_model_pkg;

  // Supported read latency window
  localparam int MIN_READ_LATENCY = 1;
  localparam int MAX_READ_LATENCY = 4;

  // Widest word the shared helpers handle; instances zero-extend into it
  localparam int MAX_WORD_SIZE = 256;
  localparam int MAX_NUM_WMASK = MAX_WORD_SIZE;

  typedef logic [MAX_WORD_SIZE-1:0] word_t;
  typedef logic [MAX_NUM_WMASK-1:0] wmask_t;

  // One read-pipeline stage
  typedef struct packed {
    logic  valid;
    word_t data;
  } pipe_stage_t;

  // Take each bit from new_word when its segment is enabled, else keep old_word
  function automatic word_t merge_wmask(input word_t  old_word,
                                        input word_t  new_word,
                                        input wmask_t mask,
                                        input int     write_size);
    word_t merged;
    for (int b = 0; b < MAX_WORD_SIZE; b++) begin
      merged[b] = mask[b / write_size] ? new_word[b] : old_word[b];
    end
    return merged;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sram_read_pipe.sv
// ============================================================================
// Module  : sram_read_pipe
// Purpose : READ_LATENCY-deep {valid,data} pipeline feeding a held output
//           register. dout keeps its last valid word; dout_valid pulses once
//           per accepted read. Reset drops everything in flight.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_read_pipe
  import sram_model_pkg::*;
#(
  parameter int WORD_SIZE    = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 accept_i,
  input  logic [WORD_SIZE-1:0] data_i,
  output logic [WORD_SIZE-1:0] dout_o,
  output logic                 dout_valid_o
);

  pipe_stage_t          stage_q [READ_LATENCY];
  pipe_stage_t          stage_d;
  logic [WORD_SIZE-1:0] dout_q;
  logic                 dout_valid_q;

  // Build the entry captured at the accept edge
  always_comb begin
    stage_d       = '0;
    stage_d.valid = accept_i;
    stage_d.data  = MAX_WORD_SIZE'(data_i);
  end

  // Shift the pipeline and update the held output register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        stage_q[i] <= '0;
      end
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      stage_q[0] <= stage_d;
      for (int i = 1; i < READ_LATENCY; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
      dout_valid_q <= stage_q[READ_LATENCY-1].valid;
      if (stage_q[READ_LATENCY-1].valid) begin
        dout_q <= stage_q[READ_LATENCY-1].data[WORD_SIZE-1:0];
      end
    end
  end

  // Upper bits of the shared stage type are always zero here
  if (WORD_SIZE < MAX_WORD_SIZE) begin : g_pad
    logic w_unused_pad;
    assign w_unused_pad = ^stage_q[READ_LATENCY-1].data[MAX_WORD_SIZE-1:WORD_SIZE];
  end

  assign dout_o       = dout_q;
  assign dout_valid_o = dout_valid_q;

endmodule

`default_nettype wire

// File: rtl/sram_1rw1r_model.sv
// ============================================================================
// Module  : sram_1rw1r_model
// Purpose : Behavioural SRAM with one read/write port (0) and one read-only
//           port (1), per-segment write mask, configurable read latency and
//           read-valid strobes. Out-of-range writes are dropped and
//           out-of-range reads return zero.
// Options : SRAM_WRITE_THROUGH_EN - a port 1 read colliding with a port 0
//           write returns the merged new word; otherwise the old word.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_1rw1r_model
  import sram_model_pkg::*;
#(
  parameter int WORD_SIZE    = 32,
  parameter int WRITE_SIZE   = 8,
  parameter int NUM_WMASK    = WORD_SIZE / WRITE_SIZE,
  parameter int ADDR_WIDTH   = 8,
  parameter int NUM_WORDS    = 1 << ADDR_WIDTH,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  csb0,
  input  logic                  web0,
  input  logic [NUM_WMASK-1:0]  wmask0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [WORD_SIZE-1:0]  din0,
  output logic [WORD_SIZE-1:0]  dout0,
  output logic                  dout0_valid,
  input  logic                  csb1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic [WORD_SIZE-1:0]  dout1,
  output logic                  dout1_valid
);

  if (READ_LATENCY < MIN_READ_LATENCY || READ_LATENCY > MAX_READ_LATENCY) begin : g_bad_latency
    $error("sram_1rw1r_model: READ_LATENCY out of range");
  end
  if ((WORD_SIZE % WRITE_SIZE) != 0 || WORD_SIZE > MAX_WORD_SIZE) begin : g_bad_word
    $error("sram_1rw1r_model: illegal WORD_SIZE/WRITE_SIZE");
  end
  if (NUM_WORDS > (1 << ADDR_WIDTH)) begin : g_bad_depth
    $error("sram_1rw1r_model: NUM_WORDS exceeds address space");
  end

  logic [WORD_SIZE-1:0] mem_q [NUM_WORDS];

  logic                 w_wr0;
  logic                 w_rd0;
  logic                 w_rd1;
  logic                 w_in0;
  logic                 w_in1;
  logic [WORD_SIZE-1:0] w_old0;
  logic [WORD_SIZE-1:0] w_merged0;
  logic [WORD_SIZE-1:0] w_rd1_data;

  // Decode accesses; X/Z on the strobes never counts as an access
  always_comb begin
    w_wr0 = rst_n && (csb0 === 1'b0) && (web0 === 1'b0);
    w_rd0 = rst_n && (csb0 === 1'b0) && (web0 === 1'b1);
    w_rd1 = rst_n && (csb1 === 1'b0);
    w_in0 = int'(addr0) < NUM_WORDS;
    w_in1 = int'(addr1) < NUM_WORDS;
  end

  // Array lookups and the masked write word (old content sampled pre-edge)
  always_comb begin
    w_old0     = w_in0 ? mem_q[addr0] : '0;
    w_merged0  = WORD_SIZE'(merge_wmask(MAX_WORD_SIZE'(w_old0), MAX_WORD_SIZE'(din0),
                                        MAX_NUM_WMASK'(wmask0), WRITE_SIZE));
    w_rd1_data = w_in1 ? mem_q[addr1] : '0;
`ifdef SRAM_WRITE_THROUGH_EN
    if (w_wr0 && w_in0 && (addr1 == addr0)) begin
      w_rd1_data = w_merged0;
    end
`endif
  end

  // Array write; contents survive reset and out-of-range writes are dropped
  always_ff @(posedge clk) begin
    if (w_wr0 && w_in0) begin
      mem_q[addr0] <= w_merged0;
    end
  end

  sram_read_pipe #(
    .WORD_SIZE    (WORD_SIZE),
    .READ_LATENCY (READ_LATENCY)
  ) u_pipe0 (
    .clk          (clk),
    .rst_n        (rst_n),
    .accept_i     (w_rd0),
    .data_i       (w_old0),
    .dout_o       (dout0),
    .dout_valid_o (dout0_valid)
  );

  sram_read_pipe #(
    .WORD_SIZE    (WORD_SIZE),
    .READ_LATENCY (READ_LATENCY)
  ) u_pipe1 (
    .clk          (clk),
    .rst_n        (rst_n),
    .accept_i     (w_rd1),
    .data_i       (w_rd1_data),
    .dout_o       (dout1),
    .dout_valid_o (dout1_valid)
  );

endmodule

`default_nettype wire

// File: tb/tb_sram_1rw1r_model.sv
// ============================================================================
// Module  : tb_sram_1rw1r_model
// Purpose : Scoreboard bench for sram_1rw1r_model (READ_LATENCY=2,
//           NUM_WORDS=200). Stimulus pushes expected reads with their due
//           edge; a negedge monitor pops and compares.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sram_1rw1r_model;

  localparam int WS  = 32;
  localparam int WRS = 8;
  localparam int NM  = WS / WRS;
  localparam int AW  = 8;
  localparam int NW  = 200;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          csb0 = 1'b1;
  logic          web0 = 1'b1;
  logic [NM-1:0] wmask0 = '0;
  logic [AW-1:0] addr0 = '0;
  logic [WS-1:0] din0 = '0;
  logic [WS-1:0] dout0;
  logic          dout0_valid;
  logic          csb1 = 1'b1;
  logic [AW-1:0] addr1 = '0;
  logic [WS-1:0] dout1;
  logic          dout1_valid;

  sram_1rw1r_model #(
    .WORD_SIZE    (WS),
    .WRITE_SIZE   (WRS),
    .ADDR_WIDTH   (AW),
    .NUM_WORDS    (NW),
    .READ_LATENCY (LAT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .csb0        (csb0),
    .web0        (web0),
    .wmask0      (wmask0),
    .addr0       (addr0),
    .din0        (din0),
    .dout0       (dout0),
    .dout0_valid (dout0_valid),
    .csb1        (csb1),
    .addr1       (addr1),
    .dout1       (dout1),
    .dout1_valid (dout1_valid)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  typedef struct {
    logic [WS-1:0] data;
    int            due;
  } exp_t;

  exp_t          q0[$];
  exp_t          q1[$];
  logic [WS-1:0] mdl [256];
  logic [WS-1:0] last0 = '0;
  logic [WS-1:0] last1 = '0;

  // Reference model: segment merge and range-checked read
  function automatic logic [WS-1:0] mdl_merge(input logic [WS-1:0] o, input logic [WS-1:0] n,
                                              input logic [NM-1:0] m);
    logic [WS-1:0] r;
    r = o;
    for (int s = 0; s < NM; s++) if (m[s]) r[s*WRS +: WRS] = n[s*WRS +: WRS];
    return r;
  endfunction

  function automatic logic [WS-1:0] mdl_read(input logic [AW-1:0] a);
    return (int'(a) < NW) ? mdl[a] : '0;
  endfunction

  // One clock of stimulus; expected results are queued against their due edge
  task automatic drive(input bit rst, input bit c0, input bit w0, input logic [NM-1:0] m,
                       input logic [AW-1:0] a0, input logic [WS-1:0] d0,
                       input bit c1, input logic [AW-1:0] a1);
    exp_t e;
    rst_n = rst; csb0 = c0; web0 = w0; wmask0 = m; addr0 = a0; din0 = d0;
    csb1 = c1; addr1 = a1;
    if (rst) begin
      if (!c0 && w0) begin
        e.data = mdl_read(a0);
        e.due  = edge_cnt + 1 + LAT;
        q0.push_back(e);
      end
      if (!c1) begin
        e.data = mdl_read(a1);
`ifdef SRAM_WRITE_THROUGH_EN
        if (!c0 && !w0 && a0 == a1 && int'(a0) < NW) e.data = mdl_merge(mdl[a0], d0, m);
`endif
        e.due = edge_cnt + 1 + LAT;
        q1.push_back(e);
      end
      if (!c0 && !w0 && int'(a0) < NW) mdl[a0] = mdl_merge(mdl[a0], d0, m);
    end
    @(posedge clk);
    #1;
    if (!rst) begin
      q0.delete();
      q1.delete();
      last0  = '0;
      last1  = '0;
      mon_en = 1'b1;
    end
  endtask

  task automatic idle();
    drive(1'b1, 1'b1, 1'b1, '0, '0, '0, 1'b1, '0);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [WS-1:0] d, input logic [NM-1:0] m);
    drive(1'b1, 1'b0, 1'b0, m, a, d, 1'b1, '0);
  endtask

  task automatic rd0(input logic [AW-1:0] a);
    drive(1'b1, 1'b0, 1'b1, '0, a, '0, 1'b1, '0);
  endtask

  task automatic rd1(input logic [AW-1:0] a);
    drive(1'b1, 1'b1, 1'b1, '0, '0, '0, 1'b0, a);
  endtask

  // Compare one port against the head of its queue
  task automatic mon_port(input int p, input logic v, input logic [WS-1:0] d);
    exp_t          e;
    bit            have;
    logic [WS-1:0] last;
    have = (p == 0) ? (q0.size() > 0) : (q1.size() > 0);
    if (have) e = (p == 0) ? q0[0] : q1[0];
    last = (p == 0) ? last0 : last1;
    checks++;
    if (v === 1'b1) begin
      if (!have) begin
        errors++;
        $display("FAIL port%0d unexpected_valid edge %0d got %h expected no read", p, edge_cnt, d);
      end else begin
        if (p == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        if (d !== e.data || edge_cnt != e.due) begin
          errors++;
          $display("FAIL port%0d read_data got %h at edge %0d expected %h at edge %0d",
                   p, d, edge_cnt, e.data, e.due);
        end
        if (p == 0) last0 = e.data; else last1 = e.data;
      end
    end else begin
      if (v !== 1'b0 || d !== last) begin
        errors++;
        $display("FAIL port%0d hold edge %0d got valid=%b data=%h expected valid=0 data=%h",
                 p, edge_cnt, v, d, last);
      end
      if (have && e.due <= edge_cnt) begin
        errors++;
        $display("FAIL port%0d missing_valid at edge %0d got none expected %h", p, e.due, e.data);
        if (p == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      end
    end
  endtask

  // Monitor samples on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (mon_en) begin
      mon_port(0, dout0_valid, dout0);
      mon_port(1, dout1_valid, dout1);
    end
  end

  initial begin
    #1;
    // Reset, then idle outputs must stay zero
    repeat (3) drive(1'b0, 1'b1, 1'b1, '0, '0, '0, 1'b1, '0);
    repeat (10) idle();

    // Fill the array so the model knows every word
    for (int a = 0; a < NW; a++) wr(AW'(a), $urandom, 4'b1111);

    // Full write then port 1 read; partial write then port 0 read
    wr(8'h05, 32'hDEADBEEF, 4'b1111);
    rd1(8'h05);
    wr(8'h05, 32'h11223344, 4'b0101);
    rd0(8'h05);
    wr(8'h06, 32'hCAFEF00D, 4'b0000);
    rd0(8'h06);

    // Same-edge collision: port 0 write, port 1 read of address 7
    wr(8'h07, 32'hAAAAAAAA, 4'b1111);
    drive(1'b1, 1'b0, 1'b0, 4'b1111, 8'h07, 32'h55555555, 1'b0, 8'h07);
    rd0(8'h07);

    // Reads accepted, reset on the following edge with a write that must not land
    drive(1'b1, 1'b0, 1'b1, '0, 8'h05, '0, 1'b0, 8'h07);
    drive(1'b0, 1'b0, 1'b0, 4'b1111, 8'h09, 32'hFFFFFFFF, 1'b0, 8'h09);
    repeat (4) idle();
    rd0(8'h09);
    repeat (3) idle();

    // Back-to-back port 1 stream over addresses 0..15
    for (int a = 0; a < 16; a++) rd1(AW'(a));
    repeat (3) idle();

    // Range boundary: 199 valid, 200 and 0xF0 outside
    wr(8'hF0, 32'h12345678, 4'b1111);
    drive(1'b1, 1'b0, 1'b1, '0, 8'hF0, '0, 1'b0, 8'hF0);
    drive(1'b1, 1'b0, 1'b1, '0, 8'd199, '0, 1'b0, 8'd200);
    repeat (3) idle();

    // Randomized traffic with occasional reset and forced collisions
    for (int i = 0; i < 2000; i++) begin
      logic [AW-1:0] a0, a1;
      a0 = AW'($urandom_range(0, 215));
      a1 = ($urandom_range(0, 3) == 0) ? a0 : AW'($urandom_range(0, 255));
      drive(($urandom_range(0, 99) != 0), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            NM'($urandom), a0, $urandom, $urandom_range(0, 2) == 0, a1);
    end

    // Drain and confirm nothing is left outstanding
    repeat (LAT + 3) idle();
    checks++;
    if (q0.size() != 0) begin
      errors++;
      $display("FAIL port0 drain got %0d outstanding expected 0", q0.size());
    end
    checks++;
    if (q1.size() != 0) begin
      errors++;
      $display("FAIL port1 drain got %0d outstanding expected 0", q1.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
